// File: rtl/mux8_rr_sched.sv
// -----------------------------------------------------------------------------
// mux8_rr_sched
//
// Round-robin scheduler that shares one 8:1 Mux8 datapath between eight
// requesters. It arbitrates level-sensitive requests and registers a one-hot
// grant together with the binary select that drives the mux. A grant is held
// for at most MAX_HOLD accepted beats before priority rotates past the
// current owner.
//
// Parameters
//   MAX_HOLD     : maximum accepted beats per grant (legal 1..15)
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   en_i         : scheduler enable; low releases the grant and blocks new ones
//   req_i[7:0]   : level request per requester; bit i selects mux input i
//   dn_ready_i   : downstream consumer accepts the mux output this cycle
//   gnt_o[7:0]   : registered one-hot grant, zero when idle
//   sel_o[2:0]   : registered binary index of the grant (mux select);
//                  keeps its last value while idle
//   sel_vld_o    : registered, equals |gnt_o
//   beat_o       : combinational transfer strobe, sel_vld & req[sel] & dn_ready
//   hold_cnt_o   : registered count of beats accepted in the current grant
// -----------------------------------------------------------------------------
module mux8_rr_sched #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [7:0] req_i,
  input  logic       dn_ready_i,
  output logic [7:0] gnt_o,
  output logic [2:0] sel_o,
  output logic       sel_vld_o,
  output logic       beat_o,
  output logic [3:0] hold_cnt_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Count value at which the next accepted beat forces rotation.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [0:0] state_q, state_d;
  logic [2:0] ptr_q,   ptr_d;
  logic [2:0] sel_q,   sel_d;
  logic [7:0] gnt_q,   gnt_d;
  logic       vld_q,   vld_d;
  logic [3:0] hold_q,  hold_d;

  logic       granted;
  logic       cur_req;
  logic       beat;
  logic       last_beat;
  logic       rel;
  logic       can_grant;
  logic [2:0] next_ptr;
  logic [2:0] pick_idle;
  logic [2:0] pick_rel;

  // First set request scanning ptr, ptr+1, ... ptr+7 (mod 8). Scanning the
  // offsets from far to near lets the nearest hit overwrite the others.
  // The result is only used when at least one request is set.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] win;
    win = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) begin
        win = idx;
      end
    end
    return win;
  endfunction

  function automatic logic [7:0] to_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  assign granted   = (state_q == ST_GRANT);
  assign cur_req   = req_i[sel_q];
  assign beat      = granted & cur_req & dn_ready_i;
  assign last_beat = beat & (hold_q == HOLD_LAST);

  // Release on owner drop, on the final permitted beat, or on disable.
  assign rel       = granted & (~cur_req | last_beat | ~en_i);
  assign can_grant = en_i & (|req_i);

  // On release the owner becomes lowest priority; the handover winner is
  // chosen against the already-rotated pointer so there is no idle cycle.
  assign next_ptr  = sel_q + 3'd1;
  assign pick_idle = rr_pick(req_i, ptr_q);
  assign pick_rel  = rr_pick(req_i, next_ptr);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          state_d = ST_GRANT;
          sel_d   = pick_idle;
          gnt_d   = to_onehot(pick_idle);
          vld_d   = 1'b1;
          hold_d  = 4'd0;
        end
      end

      ST_GRANT: begin
        if (rel) begin
          ptr_d  = next_ptr;
          hold_d = 4'd0;
          if (can_grant) begin
            sel_d = pick_rel;
            gnt_d = to_onehot(pick_rel);
            vld_d = 1'b1;
          end else begin
            // sel keeps its last value while idle.
            state_d = ST_IDLE;
            gnt_d   = 8'd0;
            vld_d   = 1'b0;
          end
        end else if (beat) begin
          hold_d = hold_q + 4'd1;
        end
        // dn_ready low: grant and count simply hold.
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'd0;
        vld_d   = 1'b0;
        hold_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
      vld_q   <= 1'b0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign sel_o      = sel_q;
  assign sel_vld_o  = vld_q;
  assign beat_o     = beat;
  assign hold_cnt_o = hold_q;

  // Structural invariants of the grant encoding.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    vld_q |-> (gnt_q == to_onehot(sel_q)));
  a_idle_zero : assert property (@(posedge clk) disable iff (!rst_n)
    !vld_q |-> (gnt_q == 8'd0));
  a_vld_state : assert property (@(posedge clk) disable iff (!rst_n)
    vld_q == granted);
  a_hold_range : assert property (@(posedge clk) disable iff (!rst_n)
    hold_q <= HOLD_LAST);

endmodule

// File: tb/tb_mux8_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux8_rr_sched
//
// Directed bench for mux8_rr_sched. Two instances share all inputs: dut uses
// MAX_HOLD=4, dut2 uses MAX_HOLD=2. Inputs change 1 time unit after a rising
// edge; registered outputs are sampled there, combinational beat 1 unit later.
// -----------------------------------------------------------------------------
module tb_mux8_rr_sched;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       dn_ready;

  logic [7:0] gnt;
  logic [2:0] sel;
  logic       vld;
  logic       beat;
  logic [3:0] hold;

  logic [7:0] gnt2;
  logic [2:0] sel2;
  logic       vld2;
  logic       beat2;
  logic [3:0] hold2;

  int checks = 0;
  int errors = 0;

  mux8_rr_sched #(.MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .req_i      (req),
    .dn_ready_i (dn_ready),
    .gnt_o      (gnt),
    .sel_o      (sel),
    .sel_vld_o  (vld),
    .beat_o     (beat),
    .hold_cnt_o (hold)
  );

  mux8_rr_sched #(.MAX_HOLD(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .req_i      (req),
    .dn_ready_i (dn_ready),
    .gnt_o      (gnt2),
    .sel_o      (sel2),
    .sel_vld_o  (vld2),
    .beat_o     (beat2),
    .hold_cnt_o (hold2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    step();
    step();
    checks++;
    if (gnt !== 8'h00) begin
      errors++; $display("FAIL reset_gnt: got %h expected 00", gnt);
    end
    checks++;
    if (vld !== 1'b0) begin
      errors++; $display("FAIL reset_vld: got %b expected 0", vld);
    end
    checks++;
    if (hold !== 4'd0) begin
      errors++; $display("FAIL reset_hold: got %0d expected 0", hold);
    end
    checks++;
    if (beat !== 1'b0) begin
      errors++; $display("FAIL reset_beat: got %b expected 0", beat);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 8'h01) begin
      errors++; $display("FAIL first_gnt: got %h expected 01", gnt);
    end
    checks++;
    if (sel !== 3'd0) begin
      errors++; $display("FAIL first_sel: got %0d expected 0", sel);
    end
    checks++;
    if (vld !== 1'b1) begin
      errors++; $display("FAIL first_vld: got %b expected 1", vld);
    end
  endtask

  // Continues from the first grant with req=FF, dn_ready=1.
  task automatic test_rotation;
    logic [2:0] exp_sel;
    logic [3:0] exp_hold;
    for (int i = 0; i < 36; i++) begin
      exp_sel  = 3'((i / 4) % 8);
      exp_hold = 4'(i % 4);
      checks++;
      if (sel !== exp_sel) begin
        errors++; $display("FAIL rot_sel[%0d]: got %0d expected %0d", i, sel, exp_sel);
      end
      checks++;
      if (gnt !== (8'h01 << exp_sel)) begin
        errors++; $display("FAIL rot_gnt[%0d]: got %h expected %h", i, gnt, 8'h01 << exp_sel);
      end
      checks++;
      if (hold !== exp_hold) begin
        errors++; $display("FAIL rot_hold[%0d]: got %0d expected %0d", i, hold, exp_hold);
      end
      checks++;
      if (beat !== 1'b1) begin
        errors++; $display("FAIL rot_beat[%0d]: got %b expected 1", i, beat);
      end
      step();
    end
  endtask

  task automatic test_stall;
    logic       rdy_seq  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] hold_seq [5] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    req = 8'h00;
    dn_ready = 1'b1;
    do_reset();
    req = 8'h20;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sel !== 3'd5 || gnt !== 8'h20) begin
        errors++; $display("FAIL stall_sel[%0d]: got sel=%0d gnt=%h expected sel=5 gnt=20", i, sel, gnt);
      end
      checks++;
      if (hold !== hold_seq[i]) begin
        errors++; $display("FAIL stall_hold[%0d]: got %0d expected %0d", i, hold, hold_seq[i]);
      end
      if (i < 4) begin
        dn_ready = rdy_seq[i];
        #1;
        checks++;
        if (beat !== rdy_seq[i]) begin
          errors++; $display("FAIL stall_beat[%0d]: got %b expected %b", i, beat, rdy_seq[i]);
        end
        step();
      end
    end
  endtask

  task automatic test_early_drop;
    req = 8'h00;
    dn_ready = 1'b1;
    do_reset();
    req = 8'h88;
    step();
    checks++;
    if (gnt !== 8'h08) begin
      errors++; $display("FAIL drop_first_gnt: got %h expected 08", gnt);
    end
    step();
    step();
    checks++;
    if (hold !== 4'd2) begin
      errors++; $display("FAIL drop_hold2: got %0d expected 2", hold);
    end
    req = 8'h80;
    #1;
    checks++;
    if (beat !== 1'b0) begin
      errors++; $display("FAIL drop_beat: got %b expected 0", beat);
    end
    step();
    checks++;
    if (gnt !== 8'h80 || sel !== 3'd7) begin
      errors++; $display("FAIL drop_gnt: got gnt=%h sel=%0d expected gnt=80 sel=7", gnt, sel);
    end
    checks++;
    if (hold !== 4'd0) begin
      errors++; $display("FAIL drop_hold: got %0d expected 0", hold);
    end
  endtask

  // Uses dut2 (MAX_HOLD=2).
  task automatic test_lone;
    req = 8'h00;
    dn_ready = 1'b1;
    do_reset();
    req = 8'h04;
    step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (gnt2 !== 8'h04 || sel2 !== 3'd2 || vld2 !== 1'b1) begin
        errors++; $display("FAIL lone_gnt[%0d]: got gnt=%h sel=%0d vld=%b expected 04/2/1", i, gnt2, sel2, vld2);
      end
      checks++;
      if (hold2 !== 4'(i % 2)) begin
        errors++; $display("FAIL lone_hold[%0d]: got %0d expected %0d", i, hold2, i % 2);
      end
      step();
    end
  endtask

  task automatic test_enable;
    req = 8'h00;
    dn_ready = 1'b1;
    en = 1'b1;
    do_reset();
    req = 8'h40;
    step();
    checks++;
    if (gnt !== 8'h40 || sel !== 3'd6) begin
      errors++; $display("FAIL en_grant6: got gnt=%h sel=%0d expected 40/6", gnt, sel);
    end
    en = 1'b0;
    step();
    checks++;
    if (gnt !== 8'h00 || vld !== 1'b0) begin
      errors++; $display("FAIL en_release: got gnt=%h vld=%b expected 00/0", gnt, vld);
    end
    checks++;
    if (sel !== 3'd6) begin
      errors++; $display("FAIL en_sel_hold: got %0d expected 6", sel);
    end
    step();
    checks++;
    if (gnt !== 8'h00) begin
      errors++; $display("FAIL en_blocked: got %h expected 00", gnt);
    end
    en = 1'b1;
    req = 8'h41;
    step();
    checks++;
    if (gnt !== 8'h01 || sel !== 3'd0) begin
      errors++; $display("FAIL en_wrap_gnt: got gnt=%h sel=%0d expected 01/0", gnt, sel);
    end
  endtask

  task automatic test_en_final_beat;
    req = 8'h00;
    dn_ready = 1'b1;
    en = 1'b1;
    do_reset();
    req = 8'h02;
    step();
    step();
    step();
    step();
    checks++;
    if (hold !== 4'd3 || gnt !== 8'h02) begin
      errors++; $display("FAIL fb_pre: got hold=%0d gnt=%h expected 3/02", hold, gnt);
    end
    en = 1'b0;
    #1;
    checks++;
    if (beat !== 1'b1) begin
      errors++; $display("FAIL fb_beat: got %b expected 1", beat);
    end
    step();
    checks++;
    if (gnt !== 8'h00 || vld !== 1'b0 || hold !== 4'd0) begin
      errors++; $display("FAIL fb_idle: got gnt=%h vld=%b hold=%0d expected 00/0/0", gnt, vld, hold);
    end
    // Pointer rotated to 2, so requester 2 beats requester 1.
    en = 1'b1;
    req = 8'h06;
    step();
    checks++;
    if (gnt !== 8'h04) begin
      errors++; $display("FAIL fb_ptr: got %h expected 04", gnt);
    end
  endtask

  task automatic test_reset_mid;
    req = 8'h00;
    dn_ready = 1'b1;
    en = 1'b1;
    do_reset();
    req = 8'h10;
    step();
    step();
    checks++;
    if (gnt !== 8'h10 || hold !== 4'd1) begin
      errors++; $display("FAIL rm_pre: got gnt=%h hold=%0d expected 10/1", gnt, hold);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || vld !== 1'b0) begin
      errors++; $display("FAIL rm_gnt: got gnt=%h vld=%b expected 00/0", gnt, vld);
    end
    checks++;
    if (sel !== 3'd0 || hold !== 4'd0) begin
      errors++; $display("FAIL rm_sel_hold: got sel=%0d hold=%0d expected 0/0", sel, hold);
    end
    checks++;
    if (beat !== 1'b0) begin
      errors++; $display("FAIL rm_beat: got %b expected 0", beat);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    req      = 8'hFF;
    dn_ready = 1'b1;
    test_reset();
    test_rotation();
    test_stall();
    test_early_drop();
    test_lone();
    test_enable();
    test_en_final_beat();
    test_reset_mid();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
